// File: rtl/adc_freq_meter.sv
// adc_freq_meter: reciprocal frequency meter (hysteresis squarer, whole-period gate); PEAK_DETECT_EN adds Vmax/Vmin capture.
// Latency: edge 2 Clk after AD_Data crosses HI_TH; results + Meas_Valid the cycle after the closing edge/timeout.
// Backpressure: none; AD_Data consumed every Clk, results hold until the next Meas_Valid.
module adc_freq_meter #(
    parameter logic [31:0] GATE_CYCLES    = 32'd50_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
    parameter logic [13:0] HI_TH          = 14'd9011,
    parameter logic [13:0] LO_TH          = 14'd7373
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Meas_En,
    input  logic [13:0] AD_Data,
    output logic [31:0] Nx_Cnt,
    output logic [31:0] Ns_Cnt,
    output logic [13:0] Vmax,
    output logic [13:0] Vmin,
    output logic        Meas_Valid,
    output logic        No_Signal,
    output logic        Busy
);

    typedef enum logic [2:0] {IDLE, ARM, GATE, CLOSE, DONE} state_t;

    state_t      state, state_nxt;
    logic [13:0] ad_q;
    logic        sig_hi, sig_hi_d, edge_det;
    logic [31:0] nx_cnt, ns_cnt, gate_cnt, to_cnt;
    logic [31:0] nx_nxt, ns_nxt, gate_nxt, to_nxt;
    logic        timeout_hit, gate_reached, fin_ok, fin_to;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ad_q     <= '0;
            sig_hi   <= 1'b0;
            sig_hi_d <= 1'b0;
        end else begin
            ad_q <= AD_Data;
            if (ad_q >= HI_TH)
                sig_hi <= 1'b1;
            else if (ad_q <= LO_TH)
                sig_hi <= 1'b0;
            sig_hi_d <= sig_hi;
        end
    end

    assign edge_det = sig_hi & ~sig_hi_d;
    // An edge in the timeout cycle restarts the timeout instead of aborting.
    assign timeout_hit  = (to_cnt == TIMEOUT_CYCLES) && !edge_det;
    // gate_cnt lags Ns by one cycle, so compare its incremented value.
    assign gate_reached = (gate_cnt + 32'd1) >= GATE_CYCLES;

    always_comb begin
        state_nxt = state;
        nx_nxt    = nx_cnt;
        ns_nxt    = ns_cnt;
        gate_nxt  = gate_cnt;
        to_nxt    = to_cnt;
        fin_ok    = 1'b0;
        fin_to    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Meas_En) begin
                    state_nxt = ARM;
                    to_nxt    = '0;
                end
            end
            ARM: begin
                if (!Meas_En) begin
                    state_nxt = IDLE;
                end else if (edge_det) begin
                    nx_nxt    = '0;
                    ns_nxt    = '0;
                    gate_nxt  = '0;
                    to_nxt    = '0;
                    state_nxt = GATE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    fin_to    = 1'b1;
                end else begin
                    to_nxt = to_cnt + 32'd1;
                end
            end
            GATE: begin
                if (!Meas_En) begin
                    state_nxt = IDLE;
                end else begin
                    ns_nxt   = ns_cnt + 32'd1;
                    gate_nxt = gate_cnt + 32'd1;
                    to_nxt   = edge_det ? '0 : to_cnt + 32'd1;
                    if (edge_det)
                        nx_nxt = nx_cnt + 32'd1;
                    if (timeout_hit) begin
                        state_nxt = DONE;
                        fin_to    = 1'b1;
                    end else if (gate_reached) begin
                        if (edge_det) begin
                            state_nxt = DONE;
                            fin_ok    = 1'b1;
                        end else begin
                            state_nxt = CLOSE;
                        end
                    end
                end
            end
            CLOSE: begin
                if (!Meas_En) begin
                    state_nxt = IDLE;
                end else begin
                    ns_nxt = ns_cnt + 32'd1;
                    to_nxt = edge_det ? '0 : to_cnt + 32'd1;
                    if (edge_det) begin
                        nx_nxt    = nx_cnt + 32'd1;
                        state_nxt = DONE;
                        fin_ok    = 1'b1;
                    end else if (timeout_hit) begin
                        state_nxt = DONE;
                        fin_to    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = Meas_En ? ARM : IDLE;
                to_nxt    = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            nx_cnt   <= '0;
            ns_cnt   <= '0;
            gate_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            nx_cnt   <= nx_nxt;
            ns_cnt   <= ns_nxt;
            gate_cnt <= gate_nxt;
            to_cnt   <= to_nxt;
        end
    end

    // Results are loaded on the edge into DONE so they appear with Meas_Valid.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Nx_Cnt    <= '0;
            Ns_Cnt    <= '0;
            No_Signal <= 1'b0;
        end else if (fin_ok) begin
            Nx_Cnt    <= nx_nxt;
            Ns_Cnt    <= ns_nxt;
            No_Signal <= 1'b0;
        end else if (fin_to) begin
            Nx_Cnt    <= '0;
            Ns_Cnt    <= '0;
            No_Signal <= 1'b1;
        end
    end

`ifdef PEAK_DETECT_EN
    logic [13:0] vmax_trk, vmin_trk, vmax_nxt, vmin_nxt;

    always_comb begin
        vmax_nxt = vmax_trk;
        vmin_nxt = vmin_trk;
        if (state == ARM && state_nxt == GATE) begin
            vmax_nxt = ad_q;
            vmin_nxt = ad_q;
        end else if (state == GATE || state == CLOSE) begin
            if (ad_q > vmax_trk)
                vmax_nxt = ad_q;
            if (ad_q < vmin_trk)
                vmin_nxt = ad_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            vmax_trk <= '0;
            vmin_trk <= '0;
            Vmax     <= '0;
            Vmin     <= '0;
        end else begin
            vmax_trk <= vmax_nxt;
            vmin_trk <= vmin_nxt;
            if (fin_ok) begin
                Vmax <= vmax_nxt;
                Vmin <= vmin_nxt;
            end else if (fin_to) begin
                Vmax <= '0;
                Vmin <= '0;
            end
        end
    end
`else
    assign Vmax = '0;
    assign Vmin = '0;
`endif

    assign Meas_Valid = (state == DONE);
    assign Busy       = (state == ARM) || (state == GATE) || (state == CLOSE);

endmodule

// File: tb/tb_adc_freq_meter.sv
// Bench for adc_freq_meter with a 1000-cycle gate and 5000-cycle timeout.
// Expected results are queued when a waveform is started and popped on each Meas_Valid.
module tb_adc_freq_meter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Meas_En;
    logic [13:0] AD_Data;
    logic [31:0] Nx_Cnt, Ns_Cnt;
    logic [13:0] Vmax, Vmin;
    logic        Meas_Valid, No_Signal, Busy;

    typedef struct {
        logic [31:0] nx;
        logic [31:0] ns;
        logic [13:0] vmax;
        logic [13:0] vmin;
        logic        nosig;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   gen_mode     = 0;
    int   gen_period   = 100;
    int   gen_idx      = 0;

    adc_freq_meter #(
        .GATE_CYCLES   (32'd1000),
        .TIMEOUT_CYCLES(32'd5000),
        .HI_TH         (14'd9011),
        .LO_TH         (14'd7373)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Meas_En   (Meas_En),
        .AD_Data   (AD_Data),
        .Nx_Cnt    (Nx_Cnt),
        .Ns_Cnt    (Ns_Cnt),
        .Vmax      (Vmax),
        .Vmin      (Vmin),
        .Meas_Valid(Meas_Valid),
        .No_Signal (No_Signal),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    // 0: constant mid-scale, 1: square 0/16383, 2: square with in-band noise shelves (p=200), 3: triangle 1000..15000 (p=200)
    function automatic logic [13:0] gen_sample(input int m, input int p, input int idx);
        int k;
        int v;
        k = idx % p;
        case (m)
            1:       v = (k < p / 2) ? 16383 : 0;
            2: begin
                if (k < 80)
                    v = 15000;
                else if (k >= 100 && k < 180)
                    v = 1000;
                else
                    v = 8192 + int'($urandom_range(1400, 0)) - 700;
            end
            3:       v = (k < 100) ? 1000 + 140 * k : 15000 - 140 * (k - 100);
            default: v = 8192;
        endcase
        return v[13:0];
    endfunction

    initial begin
        AD_Data = 14'd8192;
        forever begin
            @(negedge Clk);
            AD_Data = gen_sample(gen_mode, gen_period, gen_idx);
            gen_idx++;
        end
    end

    function automatic logic [13:0] pk(input logic [13:0] v);
`ifdef PEAK_DETECT_EN
        return v;
`else
        return 14'd0 & v;
`endif
    endfunction

    task automatic set_mode(input int m, input int p);
        Meas_En    = 1'b0;
        gen_mode   = m;
        gen_period = p;
        exp_q.delete();
        repeat (20) @(posedge Clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(posedge Clk);
            #1;
            cycles++;
            if (Meas_Valid === 1'b1)
                got = 1'b1;
        end
    endtask

    task automatic test_reset;
        Rst     = 1'b1;
        Meas_En = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        tests_run++;
        if ({Nx_Cnt, Ns_Cnt, Vmax, Vmin, Meas_Valid, No_Signal, Busy} !== 110'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: nx=%0d ns=%0d vmax=%0d vmin=%0d mv=%b nosig=%b busy=%b, required all 0",
                     Nx_Cnt, Ns_Cnt, Vmax, Vmin, Meas_Valid, No_Signal, Busy);
        end
        Rst = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        tests_run++;
        if ({Meas_Valid, Busy, Nx_Cnt} !== 34'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: mv=%b busy=%b nx=%0d, required 0 0 0", Meas_Valid, Busy, Nx_Cnt);
        end
    endtask

    task automatic test_square;
        exp_t e;
        bit   got;
        int   cyc;
        set_mode(1, 100);
        for (int i = 0; i < 2; i++)
            exp_q.push_back('{32'd10, 32'd1000, pk(14'd16383), pk(14'd0), 1'b0});
        Meas_En = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_valid(3000, got, cyc);
            tests_run++;
            if (!got) begin
                tests_failed++;
                $display("FAIL square_valid%0d: no Meas_Valid in %0d cycles, required a pulse", i, cyc);
            end else begin
                e = exp_q.pop_front();
                tests_run++;
                if ({Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal} !== {e.nx, e.ns, e.vmax, e.vmin, e.nosig}) begin
                    tests_failed++;
                    $display("FAIL square_result%0d: got nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b, required nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b",
                             i, Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal, e.nx, e.ns, e.vmax, e.vmin, e.nosig);
                end
                tests_run++;
                if (Busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL busy_in_done%0d: got %b, required 0", i, Busy);
                end
                if (i == 1) begin
                    tests_run++;
                    if (cyc !== 1100) begin
                        tests_failed++;
                        $display("FAIL back_to_back_interval: got %0d cycles, required 1100", cyc);
                    end
                end
            end
        end
        @(posedge Clk);
        #1;
        tests_run++;
        if ({Meas_Valid, Busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL pulse_width_rearm: got mv=%b busy=%b, required mv=0 busy=1", Meas_Valid, Busy);
        end
    endtask

    task automatic test_close_stretch;
        exp_t e;
        bit   got;
        int   cyc;
        set_mode(1, 300);
        exp_q.push_back('{32'd4, 32'd1200, pk(14'd16383), pk(14'd0), 1'b0});
        Meas_En = 1'b1;
        wait_valid(3000, got, cyc);
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL stretch_valid: no Meas_Valid in %0d cycles, required a pulse", cyc);
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if ({Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal} !== {e.nx, e.ns, e.vmax, e.vmin, e.nosig}) begin
                tests_failed++;
                $display("FAIL stretch_result: got nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b, required nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b",
                         Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal, e.nx, e.ns, e.vmax, e.vmin, e.nosig);
            end
        end
    endtask

    task automatic test_noisy;
        exp_t e;
        bit   got;
        int   cyc;
        set_mode(2, 200);
        exp_q.push_back('{32'd5, 32'd1000, pk(14'd15000), pk(14'd1000), 1'b0});
        Meas_En = 1'b1;
        wait_valid(3000, got, cyc);
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL noisy_valid: no Meas_Valid in %0d cycles, required a pulse", cyc);
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if ({Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal} !== {e.nx, e.ns, e.vmax, e.vmin, e.nosig}) begin
                tests_failed++;
                $display("FAIL noisy_result: got nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b, required nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b",
                         Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal, e.nx, e.ns, e.vmax, e.vmin, e.nosig);
            end
            tests_run++;
            if (64'(Nx_Cnt) * 64'd200 !== 64'(Ns_Cnt)) begin
                tests_failed++;
                $display("FAIL noisy_ratio: got nx*200=%0d ns=%0d, required equal", 64'(Nx_Cnt) * 64'd200, Ns_Cnt);
            end
        end
    endtask

    task automatic test_peak;
        exp_t e;
        bit   got;
        int   cyc;
        set_mode(3, 200);
        exp_q.push_back('{32'd5, 32'd1000, pk(14'd15000), pk(14'd1000), 1'b0});
        Meas_En = 1'b1;
        wait_valid(3000, got, cyc);
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL peak_valid: no Meas_Valid in %0d cycles, required a pulse", cyc);
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if ({Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal} !== {e.nx, e.ns, e.vmax, e.vmin, e.nosig}) begin
                tests_failed++;
                $display("FAIL peak_result: got nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b, required nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b",
                         Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal, e.nx, e.ns, e.vmax, e.vmin, e.nosig);
            end
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        bit   got;
        int   cyc;
        set_mode(0, 100);
        exp_q.push_back('{32'd0, 32'd0, 14'd0, 14'd0, 1'b1});
        Meas_En = 1'b1;
        wait_valid(6000, got, cyc);
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL timeout_valid: no Meas_Valid in %0d cycles, required a pulse", cyc);
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if ({Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal} !== {e.nx, e.ns, e.vmax, e.vmin, e.nosig}) begin
                tests_failed++;
                $display("FAIL timeout_result: got nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b, required nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b",
                         Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal, e.nx, e.ns, e.vmax, e.vmin, e.nosig);
            end
            // One edge to enter ARM plus 5001 cycles in ARM.
            tests_run++;
            if (cyc !== 5002) begin
                tests_failed++;
                $display("FAIL timeout_latency: got %0d edges after enable, required 5002", cyc);
            end
        end
    endtask

    task automatic test_en_drop;
        exp_t e;
        bit   got;
        bit   seen;
        int   cyc;
        set_mode(1, 100);
        exp_q.push_back('{32'd10, 32'd1000, pk(14'd16383), pk(14'd0), 1'b0});
        Meas_En = 1'b1;
        wait_valid(3000, got, cyc);
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL drop_first_valid: no Meas_Valid in %0d cycles, required a pulse", cyc);
        end else begin
            e = exp_q.pop_front();
            repeat (500) @(posedge Clk);
            #1;
            tests_run++;
            if (Busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL drop_busy_gate: got %b, required 1", Busy);
            end
            Meas_En = 1'b0;
            seen    = 1'b0;
            repeat (2000) begin
                @(posedge Clk);
                #1;
                if (Meas_Valid === 1'b1)
                    seen = 1'b1;
            end
            tests_run++;
            if (seen !== 1'b0) begin
                tests_failed++;
                $display("FAIL drop_no_valid: got a Meas_Valid pulse, required none");
            end
            tests_run++;
            if ({Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal, Busy} !== {e.nx, e.ns, e.vmax, e.vmin, e.nosig, 1'b0}) begin
                tests_failed++;
                $display("FAIL drop_hold: got nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b busy=%b, required nx=%0d ns=%0d vmax=%0d vmin=%0d nosig=%b busy=0",
                         Nx_Cnt, Ns_Cnt, Vmax, Vmin, No_Signal, Busy, e.nx, e.ns, e.vmax, e.vmin, e.nosig);
            end
        end
    endtask

    task automatic test_rst_close;
        exp_t e;
        bit   got;
        bit   seen;
        int   cyc;
        set_mode(1, 300);
        exp_q.push_back('{32'd4, 32'd1200, pk(14'd16383), pk(14'd0), 1'b0});
        Meas_En = 1'b1;
        wait_valid(3000, got, cyc);
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL rst_first_valid: no Meas_Valid in %0d cycles, required a pulse", cyc);
        end else begin
            e = exp_q.pop_front();
            tests_run++;
            if ({Nx_Cnt, Ns_Cnt} !== {e.nx, e.ns}) begin
                tests_failed++;
                $display("FAIL rst_first_result: got nx=%0d ns=%0d, required nx=%0d ns=%0d", Nx_Cnt, Ns_Cnt, e.nx, e.ns);
            end
            // Next E0 is 300 cycles out; 1400 cycles lands between gate end and closing edge.
            repeat (1400) @(posedge Clk);
            #1;
            tests_run++;
            if (Busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL rst_busy_close: got %b, required 1", Busy);
            end
            Rst     = 1'b1;
            Meas_En = 1'b0;
            @(posedge Clk);
            #1;
            tests_run++;
            if ({Nx_Cnt, Ns_Cnt, Vmax, Vmin, Meas_Valid, No_Signal, Busy} !== 110'd0) begin
                tests_failed++;
                $display("FAIL rst_outputs: nx=%0d ns=%0d vmax=%0d vmin=%0d mv=%b nosig=%b busy=%b, required all 0",
                         Nx_Cnt, Ns_Cnt, Vmax, Vmin, Meas_Valid, No_Signal, Busy);
            end
            @(posedge Clk);
            #1;
            Rst  = 1'b0;
            seen = 1'b0;
            repeat (1500) begin
                @(posedge Clk);
                #1;
                if (Meas_Valid === 1'b1 || Busy === 1'b1)
                    seen = 1'b1;
            end
            tests_run++;
            if ({seen, Nx_Cnt} !== 33'd0) begin
                tests_failed++;
                $display("FAIL rst_stays_idle: got activity=%b nx=%0d, required 0 0", seen, Nx_Cnt);
            end
        end
    endtask

    initial begin
        Rst     = 1'b1;
        Meas_En = 1'b0;
        test_reset;
        test_square;
        test_close_stretch;
        test_noisy;
        test_peak;
        test_timeout;
        test_en_drop;
        test_rst_close;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
